mcpu_ram_master: RTL and testbench
==================================

Name: mcpu_ram_master

Overview:
- Initiator-side companion to MCPU_RAMController.
- Turns core-side load/store requests (valid/ready handshake) and instruction-fetch requests into the controller's strobe-level signals: we, re, addr, datawr on the data port; instraddr on the instruction port.
- Registers returned read data and presents it with a one-cycle valid pulse.
- Sits between the micro-CPU core and the RAM controller. It is the only block that drives the RAM controller.

Parameters:
- WORD_SIZE, 8, data/instruction word width in bits
- ADDR_WIDTH, 8, RAM address width; RAM depth is 1<<ADDR_WIDTH

Ports:
- clk  in  1  single system clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- d_valid  in  1  core data request valid
- d_ready  out  1  data request accepted when d_valid && d_ready at a rising edge
- d_write  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data request address
- d_wdata  in  WORD_SIZE  store data
- d_rvalid  out  1  one-cycle pulse; d_rdata valid
- d_rdata  out  WORD_SIZE  load result
- f_valid  in  1  fetch request valid
- f_addr  in  ADDR_WIDTH  fetch address
- f_ready  out  1  fetch accepted when f_valid && f_ready at a rising edge
- f_rvalid  out  1  one-cycle pulse; f_rdata valid
- f_rdata  out  WORD_SIZE  fetched instruction
- we  out  1  to RAM controller write enable
- re  out  1  to RAM controller read enable
- addr  out  ADDR_WIDTH  to RAM controller data address
- datawr  out  WORD_SIZE  to RAM controller write data
- datard  in  WORD_SIZE  from RAM controller read data (combinational from addr)
- instraddr  out  ADDR_WIDTH  to RAM controller instruction address
- instrrd  in  WORD_SIZE  from RAM controller instruction data (combinational)
- busy  out  1  data FSM not in IDLE
- err  out  1  sticky readback mismatch (feature only)

Behaviour:
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE
  - we=0, re=0, addr=0, datawr=0, instraddr=0
  - d_rvalid=0, f_rvalid=0, d_rdata=0, f_rdata=0
  - busy=0, err=0
  - d_ready=0 and f_ready=0 while rst_n=0; both become 1 in the first cycle after deassertion.
- Reset mid-transaction drops the transaction and produces no rvalid; we/re fall without waiting for a clock edge.
- Data FSM states:
  - IDLE: d_ready=1. On accept, latch d_addr/d_wdata/d_write; go to WR_SETUP if d_write, else RD_STROBE.
  - WR_SETUP: addr/datawr driven from latches; we=0.
  - WR_STROBE: we=1 for exactly one cycle.
  - WR_HOLD: we=0; addr/datawr unchanged. Then go to IDLE, or RB_STROBE with the feature.
  - RD_STROBE: re=1, addr driven. At the closing edge d_rdata<=datard, go to IDLE, and d_rvalid=1 for the following cycle.
- Timing:
  - Load: accept at edge E0, d_rvalid high in the cycle after E1.
  - Store: d_ready returns 1 three cycles after accept.
  - Back-to-back accepts allowed from the IDLE cycle.
- Strobe rules:
  - we and re are never both 1.
  - re is 1 only in RD_STROBE/RB_STROBE; we is 1 only in WR_STROBE.
  - addr/datawr hold their last values in IDLE.
- Fetch port (independent pipeline, throughput 1/cycle, latency 2):
  - On accept at edge E0, instraddr<=f_addr.
  - At E1, f_rdata<=instrrd; f_rvalid=1 in the cycle after E1.
  - Consecutive accepts produce consecutive f_rvalid pulses, in order.
- Write/fetch hazard:
  - f_ready=0 while state is WR_SETUP, WR_STROBE or WR_HOLD and f_addr equals the latched write address.
  - Otherwise f_ready=1.
  - A fetch to a just-written address therefore always returns the new data.
- Address wrap: no address arithmetic. The full ADDR_WIDTH range 0..(1<<ADDR_WIDTH)-1 is legal, including address 255 at the default width.
- d_valid while not ready is ignored. The core holds its request stable until accepted.

Optional Feature:
- Macro: MCPU_RAM_MASTER_READBACK_EN.
- Defined:
  - WR_HOLD goes to RB_STROBE (re=1 for one cycle, addr unchanged).
  - At its closing edge, datard is compared with the latched wdata; a mismatch sets err=1 until reset.
  - No d_rvalid is generated for the readback.
  - Store occupancy becomes 4 cycles.
- Undefined: no RB_STROBE state; err tied to 0.

Decomposition:
- Package mcpu_mem_pkg holds:
  - WORD_SIZE/ADDR_WIDTH defaults
  - data FSM state enum (IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RB_STROBE)
  - request struct typedef (write, addr, wdata)
- Sub-module mcpu_fetch_port holds the two-stage fetch pipeline and hazard compare. It takes the write-window flag and the latched write address as inputs.

Test Plan:
- Store 44 to addr 0, then load addr 0 -> we high for exactly 1 cycle; controller mem[0]=44; d_rdata=44 with d_rvalid 2 cycles after load accept.
- Store alternating 44/56 to all 256 addresses, then fetch 0..255 back-to-back -> f_rvalid high 256 consecutive cycles; f_rdata matches the pattern; addr 255 is handled correctly.
- Store 0x5A to addr 7 while fetching addr 7 -> f_ready=0 during the write window; the fetch returns 0x5A.
- Concurrent load of addr 3 and fetches of addr 4,5 -> all complete at the specified latencies; we/re never both 1.
- Assert rst_n=0 during WR_STROBE -> we drops immediately; no d_rvalid; outputs at reset values; the next store after release completes normally.
- With MCPU_RAM_MASTER_READBACK_EN, force datard to 0xFF while storing 0x12 -> err=1 and it stays set; d_ready returns 4 cycles after accept.

Source files
------------

// File: rtl/mcpu_mem_pkg.sv
// Shared defaults and types for the micro-CPU RAM master and its fetch port.
package mcpu_mem_pkg;

    localparam int DEF_WORD_SIZE  = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_STROBE,
        RB_STROBE
    } state_t;

    // Core-side data request; field widths follow the package defaults.
    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WORD_SIZE-1:0]  wdata;
    } req_t;

endpackage

// File: rtl/mcpu_fetch_port.sv
// Two-stage instruction fetch pipeline with a write-address hazard stall.
module mcpu_fetch_port
    import mcpu_mem_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  active,
    input  logic                  f_valid,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ready,
    output logic                  f_rvalid,
    output logic [WORD_SIZE-1:0]  f_rdata,
    output logic [ADDR_WIDTH-1:0] instraddr,
    input  logic [WORD_SIZE-1:0]  instrrd,
    input  logic                  wr_window,
    input  logic [ADDR_WIDTH-1:0] wr_addr
);

    logic pending;
    logic f_accept;

    // Stalling a fetch that targets the in-flight store keeps it from reading stale data.
    assign f_ready  = active && !(wr_window && (f_addr == wr_addr));
    assign f_accept = f_valid && f_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instraddr <= '0;
            pending   <= 1'b0;
            f_rvalid  <= 1'b0;
            f_rdata   <= '0;
        end else begin
            pending  <= f_accept;
            f_rvalid <= pending;
            if (f_accept) begin
                instraddr <= f_addr;
            end
            if (pending) begin
                f_rdata <= instrrd;
            end
        end
    end

endmodule

// File: rtl/mcpu_ram_master.sv
// Initiator that drives the MCPU RAM controller strobes from core load/store/fetch requests.
// Optional store readback check enabled by defining MCPU_RAM_MASTER_READBACK_EN.
module mcpu_ram_master
    import mcpu_mem_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_rvalid,
    output logic [WORD_SIZE-1:0]  d_rdata,
    input  logic                  f_valid,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ready,
    output logic                  f_rvalid,
    output logic [WORD_SIZE-1:0]  f_rdata,
    output logic                  we,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WORD_SIZE-1:0]  datawr,
    input  logic [WORD_SIZE-1:0]  datard,
    output logic [ADDR_WIDTH-1:0] instraddr,
    input  logic [WORD_SIZE-1:0]  instrrd,
    output logic                  busy,
    output logic                  err
);

    state_t state, state_next;
    req_t   req_in;
    logic   active;
    logic   d_accept;
    logic   wr_window;

    assign req_in    = '{write: d_write, addr: d_addr, wdata: d_wdata};
    assign d_ready   = active && (state == IDLE);
    assign d_accept  = d_valid && d_ready;
    assign busy      = (state != IDLE);
    assign we        = (state == WR_STROBE);
    assign re        = (state == RD_STROBE) || (state == RB_STROBE);
    assign wr_window = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);

    // Both ports stay closed until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_accept) begin
                    state_next = req_in.write ? WR_SETUP : RD_STROBE;
                end
            end
            WR_SETUP:  state_next = WR_STROBE;
            WR_STROBE: state_next = WR_HOLD;
`ifdef MCPU_RAM_MASTER_READBACK_EN
            WR_HOLD:   state_next = RB_STROBE;
`else
            WR_HOLD:   state_next = IDLE;
`endif
            RD_STROBE: state_next = IDLE;
            RB_STROBE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // addr/datawr double as the request latch so they stay put through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            datawr <= '0;
        end else if (d_accept) begin
            addr <= req_in.addr;
            if (req_in.write) begin
                datawr <= req_in.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            d_rvalid <= (state == RD_STROBE);
            if (state == RD_STROBE) begin
                d_rdata <= datard;
            end
        end
    end

`ifdef MCPU_RAM_MASTER_READBACK_EN
    // Sticky until reset so a single corrupted store is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == RB_STROBE) && (datard != datawr)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    mcpu_fetch_port #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .f_valid   (f_valid),
        .f_addr    (f_addr),
        .f_ready   (f_ready),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .instraddr (instraddr),
        .instrrd   (instrrd),
        .wr_window (wr_window),
        .wr_addr   (addr)
    );

endmodule

// File: tb/tb_mcpu_ram_master.sv
// Self-checking bench for mcpu_ram_master with a behavioural RAM controller and reference memory.
module tb_mcpu_ram_master;

`ifdef MCPU_RAM_MASTER_READBACK_EN
    localparam int STORE_CYC = 4;
`else
    localparam int STORE_CYC = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid, d_ready, d_write, d_rvalid;
    logic [7:0] d_addr, d_wdata, d_rdata;
    logic       f_valid, f_ready, f_rvalid;
    logic [7:0] f_addr, f_rdata;
    logic       we, re, busy, err;
    logic [7:0] addr, datawr, datard, instraddr, instrrd;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    logic       force_bad;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int we_cycles = 0;
    int frv_count = 0;
    int frv_run   = 0;
    int frv_peak  = 0;

    typedef struct {
        int         due;
        logic [7:0] data;
    } fexp_t;
    fexp_t fq[$];

    always #5 clk = ~clk;

    mcpu_ram_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .f_valid   (f_valid),
        .f_addr    (f_addr),
        .f_ready   (f_ready),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .datawr    (datawr),
        .datard    (datard),
        .instraddr (instraddr),
        .instrrd   (instrrd),
        .busy      (busy),
        .err       (err)
    );

    // Behavioural RAM controller: combinational reads, write on the clock while we is high.
    assign datard  = force_bad ? 8'hFF : ram[addr];
    assign instrrd = ram[instraddr];
    always @(posedge clk) begin
        if (we) ram[addr] <= datawr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fetch scoreboard: an accepted fetch must return the reference word two edges later.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            fq.delete();
            frv_run = 0;
        end else begin
            checkOutput("we_re_exclusive", 32'(we && re), 0);
            if (we) we_cycles++;
            if (fq.size() > 0 && fq[0].due == cyc) begin
                checkOutput("f_rvalid", 32'(f_rvalid), 1);
                checkOutput("f_rdata", 32'(f_rdata), 32'(fq[0].data));
                void'(fq.pop_front());
            end else begin
                checkOutput("f_rvalid_idle", 32'(f_rvalid), 0);
            end
            if (f_rvalid) begin
                frv_count++;
                frv_run++;
                if (frv_run > frv_peak) frv_peak = frv_run;
            end else begin
                frv_run = 0;
            end
            if (f_valid && f_ready) fq.push_back('{due: cyc + 2, data: ref_mem[f_addr]});
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitDataReady(output int waited);
        waited = 0;
        @(negedge clk);
        while (!d_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        checkOutput("d_accept_timeout", 32'(waited < 50), 1);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int waited;
        int n;
        int we0;
        logic [7:0] exp;
        d_valid = 1'b1;
        d_write = wr;
        d_addr  = a;
        d_wdata = d;
        waitDataReady(waited);
        we0 = we_cycles;
        @(posedge clk); #1;
        d_valid = 1'b0;
        if (wr) begin
            for (n = 1; n <= 10; n++) begin
                @(posedge clk); #1;
                if (n == 2) ref_mem[a] = d;
                checkOutput("store_no_rvalid", 32'(d_rvalid), 0);
                if (d_ready) break;
            end
            checkOutput("store_occupancy", 32'(n), 32'(STORE_CYC));
            checkOutput("store_we_cycles", 32'(we_cycles - we0), 1);
            checkOutput("ram_written", 32'(ram[a]), 32'(d));
        end else begin
            exp = ref_mem[a];
            checkOutput("load_rvalid_early", 32'(d_rvalid), 0);
            @(posedge clk); #1;
            checkOutput("load_rvalid", 32'(d_rvalid), 1);
            checkOutput("load_rdata", 32'(d_rdata), 32'(exp));
            @(posedge clk); #1;
            checkOutput("load_rvalid_pulse", 32'(d_rvalid), 0);
            checkOutput("load_ready_back", 32'(d_ready), 1);
        end
    endtask

    task automatic applyFetch(input logic [7:0] a, output int stalls);
        f_valid = 1'b1;
        f_addr  = a;
        stalls  = 0;
        @(negedge clk);
        while (!f_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        checkOutput("f_accept_timeout", 32'(stalls < 50), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] a, d;
        int op;
        int stalls;
        int frv0;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        force_bad = 1'b0;
        rst_n   = 1'b1;
        d_valid = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        f_valid = 1'b0;
        f_addr  = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_re", 32'(re), 0);
        checkOutput("rst_addr", 32'(addr), 0);
        checkOutput("rst_datawr", 32'(datawr), 0);
        checkOutput("rst_instraddr", 32'(instraddr), 0);
        checkOutput("rst_d_rvalid", 32'(d_rvalid), 0);
        checkOutput("rst_f_rvalid", 32'(f_rvalid), 0);
        checkOutput("rst_d_rdata", 32'(d_rdata), 0);
        checkOutput("rst_f_rdata", 32'(f_rdata), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_d_ready", 32'(d_ready), 0);
        checkOutput("rst_f_ready", 32'(f_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_d_ready", 32'(d_ready), 1);
        checkOutput("post_rst_f_ready", 32'(f_ready), 1);

        $display("[TB] store 44 to 0, load it back");
        applyStimulus(1'b1, 8'd0, 8'd44);
        applyStimulus(1'b0, 8'd0, 8'd0);

        $display("[TB] alternating pattern over the full address range");
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), (i % 2 == 0) ? 8'd44 : 8'd56);
        frv0 = frv_count;
        frv_peak = 0;
        for (int i = 0; i < 256; i++) applyFetch(8'(i), stalls);
        f_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("burst_rvalid_count", 32'(frv_count - frv0), 256);
        checkOutput("burst_rvalid_run", 32'(frv_peak), 256);
        checkOutput("ram_top_addr", 32'(ram[255]), 56);

        $display("[TB] store/fetch hazard on address 7");
        fork
            applyStimulus(1'b1, 8'd7, 8'h5A);
            begin
                @(posedge clk); #1;
                applyFetch(8'd7, stalls);
                f_valid = 1'b0;
                checkOutput("hazard_stalls", 32'(stalls), 3);
            end
        join
        @(posedge clk); #1;
        checkOutput("hazard_fetch_data", 32'(f_rdata), 'h5A);

        $display("[TB] concurrent load and fetches");
        fork
            applyStimulus(1'b0, 8'd3, 8'd0);
            begin
                applyFetch(8'd4, stalls);
                applyFetch(8'd5, stalls);
                f_valid = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 30; i++) begin
            a  = 8'($urandom_range(0, 15));
            d  = 8'($urandom);
            op = int'($urandom_range(0, 1));
            fork
                applyStimulus(op == 1, a, d);
                begin
                    repeat (3) applyFetch(8'($urandom_range(0, 15)), stalls);
                    f_valid = 1'b0;
                end
            join
        end
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset during write strobe");
        d_valid = 1'b1;
        d_write = 1'b1;
        d_addr  = 8'd20;
        d_wdata = 8'd77;
        waitDataReady(op);
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_we_before", 32'(we), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we", 32'(we), 0);
        checkOutput("abort_re", 32'(re), 0);
        checkOutput("abort_addr", 32'(addr), 0);
        checkOutput("abort_datawr", 32'(datawr), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_d_ready", 32'(d_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_rvalid", 32'(d_rvalid), 0);
            checkOutput("abort_idle", 32'(busy), 0);
        end
        checkOutput("abort_ram_untouched", 32'(ram[20]), 32'(ref_mem[20]));
        applyStimulus(1'b1, 8'd20, 8'd77);
        applyStimulus(1'b0, 8'd20, 8'd0);

`ifdef MCPU_RAM_MASTER_READBACK_EN
        $display("[TB] readback mismatch sets err");
        force_bad = 1'b1;
        applyStimulus(1'b1, 8'd9, 8'h12);
        force_bad = 1'b0;
        checkOutput("rb_err_set", 32'(err), 1);
        applyStimulus(1'b0, 8'd9, 8'd0);
        checkOutput("rb_err_sticky", 32'(err), 1);
`else
        checkOutput("err_tied_low", 32'(err), 0);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
